// File: rtl/state_sequencer_pkg.sv
// Shared definitions for the instruction step sequencer and its step decoder.
// Holds the step-code width, the idle code, the FSM state type and the named step codes.
package seq_pkg;

  localparam int STATE_W            = 4;
  localparam int NUM_STATES_DEFAULT = 9;
  localparam int SEL_W              = 15;

  // Decoders treat this code as "no step active" and drive an all-zero selector.
  localparam logic [STATE_W-1:0] IDLE_CODE = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam logic [STATE_W-1:0] STEP_FETCH = 4'd0;
  localparam logic [STATE_W-1:0] STEP_1     = 4'd1;
  localparam logic [STATE_W-1:0] STEP_2     = 4'd2;
  localparam logic [STATE_W-1:0] STEP_3     = 4'd3;
  localparam logic [STATE_W-1:0] STEP_4     = 4'd4;
  localparam logic [STATE_W-1:0] STEP_5     = 4'd5;
  localparam logic [STATE_W-1:0] STEP_6     = 4'd6;
  localparam logic [STATE_W-1:0] STEP_7     = 4'd7;
  localparam logic [STATE_W-1:0] STEP_8     = 4'd8;

  // One-hot selector for a step code; IDLE_CODE maps to all zeros.
  function automatic logic [SEL_W-1:0] step_selector(input logic [STATE_W-1:0] code);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      if (code == STATE_W'(i)) sel[i] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/state_sequencer_if.sv
// Issue-side bundle of the step sequencer: start/ready handshake, run controls and status.
// The issue logic uses the master modport, the sequencer the slave modport.
interface state_sequencer_if #(
  parameter int STATE_W = seq_pkg::STATE_W,
  parameter int CNT_W   = 16
);

  logic               start;
  logic               ready;
  logic               stall;
  logic               early_end;
  logic               abort;
  logic [STATE_W-1:0] current_state;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output start, stall, early_end, abort,
    input  ready, current_state, busy, done, instr_count
  );

  modport slave (
    input  start, stall, early_end, abort,
    output ready, current_state, busy, done, instr_count
  );

endinterface

// File: rtl/state_sequencer.sv
// Instruction step sequencer: walks step codes 0..NUM_STATES-1, then parks on IDLE_CODE.
// Define SEQ_BACK2BACK_EN to accept the next start in the final step (no idle gap).
module state_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STATES = seq_pkg::NUM_STATES_DEFAULT,
  parameter int STATE_W    = seq_pkg::STATE_W,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  state_sequencer_if.slave  seq
);

  localparam logic [STATE_W-1:0] LAST_STEP = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] IDLE_STEP = STATE_W'(IDLE_CODE);

  seq_state_e         state_q, state_d;
  logic [STATE_W-1:0] step_q,  step_d;
  logic               done_q,  done_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ready;
  logic               end_cond;

  // Priority inside RUN is abort > stall > end > advance.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    end_cond = seq.early_end || (step_q == LAST_STEP);

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (seq.start) begin
          state_d = RUN;
          step_d  = '0;
        end
      end

      RUN: begin
        if (seq.abort) begin
          state_d = IDLE;
          step_d  = IDLE_STEP;
        end else if (!seq.stall) begin
          if (end_cond) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
`ifdef SEQ_BACK2BACK_EN
            ready = 1'b1;
            if (seq.start) begin
              step_d = '0;
            end else begin
              state_d = IDLE;
              step_d  = IDLE_STEP;
            end
`else
            state_d = IDLE;
            step_d  = IDLE_STEP;
`endif
          end else begin
            step_d = step_q + STATE_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        step_d  = IDLE_STEP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= IDLE_STEP;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seq.ready         = ready;
  assign seq.current_state = step_q;
  assign seq.busy          = (state_q == RUN);
  assign seq.done          = done_q;
  assign seq.instr_count   = cnt_q;

  // Step codes between the last step and the idle code must never reach the decoder.
  a_legal_code: assert property (@(posedge clk) disable iff (!rst_n)
    (step_q == IDLE_STEP) || (step_q <= LAST_STEP));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> !done_q);

  a_idle_code: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> (step_q == IDLE_STEP));

endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: a sequence-position model predicts each cycle's outputs.
module tb_state_sequencer;

  localparam int NUM   = 9;
  localparam int CNT_W = 4;
`ifdef SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct {
    logic [3:0]       cs;
    logic             busy;
    logic             done;
    logic             ready;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Model: m_pos = -1 when idle, otherwise the step index being executed.
  int m_pos  = -1;
  bit m_done = 1'b0;
  int m_cnt  = 0;

  state_sequencer_if #(.STATE_W(4), .CNT_W(CNT_W)) sif ();

  state_sequencer #(.NUM_STATES(NUM), .STATE_W(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("current_state", 32'(sif.current_state), 32'(e.cs));
      chk("busy",          32'(sif.busy),          32'(e.busy));
      chk("done",          32'(sif.done),          32'(e.done));
      chk("ready",         32'(sif.ready),         32'(e.ready));
      chk("instr_count",   32'(sif.instr_count),   32'(e.cnt));
    end
  end

  task automatic cycle(input bit st, input bit sl, input bit ee, input bit ab);
    exp_t e;
    bit   ends;
    @(posedge clk);
    #1;
    sif.start     = st;
    sif.stall     = sl;
    sif.early_end = ee;
    sif.abort     = ab;
    e.cs    = (m_pos < 0) ? 4'hF : 4'(m_pos);
    e.busy  = (m_pos >= 0);
    e.done  = m_done;
    e.cnt   = CNT_W'(m_cnt);
    ends    = (m_pos >= 0) && !ab && !sl && (ee || m_pos == NUM - 1);
    e.ready = (m_pos < 0) || (B2B && ends);
    q.push_back(e);
    if (m_pos < 0) begin
      m_done = 1'b0;
      if (st) m_pos = 0;
    end else if (ab) begin
      m_pos  = -1;
      m_done = 1'b0;
    end else if (sl) begin
      m_done = 1'b0;
    end else if (ends) begin
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      m_done = 1'b1;
      m_pos  = (st && e.ready) ? 0 : -1;
    end else begin
      m_pos  = m_pos + 1;
      m_done = 1'b0;
    end
  endtask

  task automatic idle_until(input int step);
    for (int n = 0; n < 40 && m_pos != step; n++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    if (m_pos != step) begin
      errors++;
      $display("FAIL reach_step: model at %0d expected %0d", m_pos, step);
    end
  endtask

  task automatic reset_now();
    @(posedge clk);
    #1;
    sif.start = 1'b0; sif.stall = 1'b0; sif.early_end = 1'b0; sif.abort = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_current_state", 32'(sif.current_state), 32'hF);
    chk("rst_busy",          32'(sif.busy),          32'h0);
    chk("rst_done",          32'(sif.done),          32'h0);
    chk("rst_instr_count",   32'(sif.instr_count),   32'h0);
    chk("rst_ready",         32'(sif.ready),         32'h1);
    m_pos = -1; m_done = 1'b0; m_cnt = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    sif.start = 1'b0; sif.stall = 1'b0; sif.early_end = 1'b0; sif.abort = 1'b0;
    #12 rst_n = 1'b1;

    // Full unstalled run, then reset in the middle of the next one at step 3.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_until(3);
    reset_now();

    // Stall three cycles at step 2, then early end at step 4.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_until(2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    idle_until(4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort wins over stall at step 5.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_until(5);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Start held high across several sequences.
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Sixteen completions from reset wrap the 4-bit counter back to zero.
    reset_now();
    for (int r = 0; r < 16; r++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < NUM + 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(1, 0) == 1),
            ($urandom_range(4, 0) == 0),
            ($urandom_range(9, 0) == 0),
            ($urandom_range(29, 0) == 0));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
